// File: rtl/arbitro_clases_param_if.sv
// rtl/arbitro_clases_param_if.sv - ingress/class FIFO bundle seen by the class router
// master = router side (pops ingress, pushes class FIFOs); slave = FIFO side.
interface arbitro_clases_param_if #(
  parameter int DATA_W = 12,
  parameter int NUM_CH = 4
);
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;
  logic              pop;
  logic [NUM_CH-1:0] almost_full;
  logic [NUM_CH-1:0] push;
  logic [DATA_W-1:0] data_out;

  modport master (
    input  fifo_data, fifo_empty, almost_full,
    output pop, push, data_out
  );

  modport slave (
    output fifo_data, fifo_empty, almost_full,
    input  pop, push, data_out
  );
endinterface

// File: rtl/arbitro_clases_param.sv
// rtl/arbitro_clases_param.sv - routes ingress FIFO words to per-class FIFOs via a one-entry hold
// Hold stage is the FSM (EMPTY/FULL); push/data_out are registered, pop is combinational.
module arbitro_clases_param #(
  parameter int DATA_W    = 12,
  parameter int CLASS_W   = 2,
  parameter int CLASS_LSB = 10,
  parameter int MODE      = 0,
  parameter int CNT_W     = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             cnt_clr,
  arbitro_clases_param_if.master           bus,
  output logic [(2**CLASS_W)*CNT_W-1:0]    push_cnt
);
  localparam int NUM_CH = 2**CLASS_W;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic [CLASS_W-1:0]  dest;
  logic                blocked;
  logic                drain;
  logic                pop;
  logic [NUM_CH-1:0]   push_q, push_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [CNT_W-1:0]    cnt_q [NUM_CH];
  logic [CNT_W-1:0]    cnt_d [NUM_CH];

  assign dest    = hold_data_q[CLASS_LSB +: CLASS_W];
  assign blocked = (MODE != 0) ? bus.almost_full[dest] : |bus.almost_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
    end
  end

  // A pop refills the hold even while it drains, which keeps 1 word/cycle.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    if (pop) begin
      state_d     = FULL;
      hold_data_d = bus.fifo_data;
    end else if (drain) begin
      state_d     = EMPTY;
    end
  end

  always_comb begin
    drain = (state_q == FULL) & ~blocked & enable;
    pop   = ~reset & enable & ~bus.fifo_empty & ((state_q == EMPTY) | drain);
  end

  always_comb begin
    push_d     = '0;
    data_out_d = data_out_q;
    if (drain) begin
      push_d[dest] = 1'b1;
      data_out_d   = hold_data_q;
    end
  end

  // Counters step on the same edge that registers the push; clear wins.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k] = cnt_q[k];
      if (cnt_clr) begin
        cnt_d[k] = '0;
      end else if (push_d[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      push_q     <= '0;
      data_out_q <= '0;
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else begin
      push_q     <= push_d;
      data_out_q <= data_out_d;
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_comb begin
    push_cnt = '0;
    for (int k = 0; k < NUM_CH; k++) push_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end

  assign bus.pop      = pop;
  assign bus.push     = push_q;
  assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_arbitro_clases_param.sv
// tb/tb_arbitro_clases_param.sv - directed bench: MODE=0, MODE=1 and CNT_W=3 routers on shared stimulus
// Every scenario starts from reset, so the three instances may diverge freely inside a scenario.
module tb_arbitro_clases_param;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        cnt_clr;
  logic [11:0] fifo_data;
  logic        fifo_empty;
  logic [3:0]  almost_full;
  logic [31:0] push_cnt0;
  logic [31:0] push_cnt1;
  logic [11:0] push_cnt2;
  int          passed = 0;
  int          total  = 0;

  arbitro_clases_param_if #(.DATA_W(12), .NUM_CH(4)) if0 ();
  arbitro_clases_param_if #(.DATA_W(12), .NUM_CH(4)) if1 ();
  arbitro_clases_param_if #(.DATA_W(12), .NUM_CH(4)) if2 ();

  assign if0.fifo_data = fifo_data;  assign if0.fifo_empty = fifo_empty;  assign if0.almost_full = almost_full;
  assign if1.fifo_data = fifo_data;  assign if1.fifo_empty = fifo_empty;  assign if1.almost_full = almost_full;
  assign if2.fifo_data = fifo_data;  assign if2.fifo_empty = fifo_empty;  assign if2.almost_full = almost_full;

  arbitro_clases_param #(.MODE(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .cnt_clr(cnt_clr), .bus(if0), .push_cnt(push_cnt0));
  arbitro_clases_param #(.MODE(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .cnt_clr(cnt_clr), .bus(if1), .push_cnt(push_cnt1));
  arbitro_clases_param #(.MODE(0), .CNT_W(3)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .cnt_clr(cnt_clr), .bus(if2), .push_cnt(push_cnt2));

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; cnt_clr = 1'b0;
    fifo_empty = 1'b1; fifo_data = '0; almost_full = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (if0.push !== 4'b0) $display("FAIL reset_push: got %b expected 0000", if0.push); else passed++;
    total++; if (if0.data_out !== 12'h0) $display("FAIL reset_data_out: got %h expected 000", if0.data_out); else passed++;
    total++; if (push_cnt0 !== 32'h0) $display("FAIL reset_push_cnt: got %h expected 0", push_cnt0); else passed++;
    almost_full = 4'b1111; fifo_data = 12'h123; fifo_empty = 1'b0; #1;
    total++; if (if0.pop !== 1'b1) $display("FAIL reset_load_pop: got %b expected 1", if0.pop); else passed++;
    @(posedge clk); #1; fifo_empty = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; almost_full = 4'b0; fifo_empty = 1'b0; #1;
    total++; if (if0.pop !== 1'b0) $display("FAIL reset_pop_forced: got %b expected 0", if0.pop); else passed++;
    @(posedge clk); #1; reset = 1'b0; fifo_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (if0.push !== 4'b0) $display("FAIL reset_discard_push[%0d]: got %b expected 0000", i, if0.push); else passed++;
    end
    total++; if (if0.data_out !== 12'h0) $display("FAIL reset_discard_data: got %h expected 000", if0.data_out); else passed++;
    total++; if (push_cnt0 !== 32'h0) $display("FAIL reset_discard_cnt: got %h expected 0", push_cnt0); else passed++;
  endtask

  task automatic test_stream();
    logic [11:0] w [4];
    logic        exp_pop;
    w[0] = 12'h011; w[1] = 12'h422; w[2] = 12'h833; w[3] = 12'hC44;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin fifo_data = w[i]; fifo_empty = 1'b0; end
      else fifo_empty = 1'b1;
      exp_pop = (i < 4);
      #1;
      total++; if (if0.pop !== exp_pop) $display("FAIL stream_pop[%0d]: got %b expected %b", i, if0.pop, exp_pop); else passed++;
      @(posedge clk); #1;
      if (i >= 1 && i <= 4) begin
        total++; if (if0.push !== 4'(1 << (i-1))) $display("FAIL stream_push[%0d]: got %b expected %b", i, if0.push, 4'(1 << (i-1))); else passed++;
        total++; if (if0.data_out !== w[i-1]) $display("FAIL stream_data[%0d]: got %h expected %h", i, if0.data_out, w[i-1]); else passed++;
      end else begin
        total++; if (if0.push !== 4'b0) $display("FAIL stream_idle_push[%0d]: got %b expected 0000", i, if0.push); else passed++;
      end
    end
    total++; if (push_cnt0 !== 32'h01010101) $display("FAIL stream_cnt: got %h expected 01010101", push_cnt0); else passed++;
  endtask

  task automatic test_global_stall();
    do_reset();
    almost_full = 4'b0100; fifo_data = 12'h055; fifo_empty = 1'b0; #1;
    total++; if (if0.pop !== 1'b1) $display("FAIL gstall_first_pop: got %b expected 1", if0.pop); else passed++;
    @(posedge clk); #1;
    fifo_data = 12'h456; #1;
    total++; if (if1.pop !== 1'b1) $display("FAIL gstall_mode1_pop: got %b expected 1", if1.pop); else passed++;
    for (int i = 0; i < 2; i++) begin
      total++; if (if0.pop !== 1'b0) $display("FAIL gstall_pop[%0d]: got %b expected 0", i, if0.pop); else passed++;
      @(posedge clk); #1;
      total++; if (if0.push !== 4'b0) $display("FAIL gstall_push[%0d]: got %b expected 0000", i, if0.push); else passed++;
    end
    almost_full = 4'b0; fifo_empty = 1'b1; #1;
    @(posedge clk); #1;
    total++; if (if0.push !== 4'b0001) $display("FAIL gstall_release_push: got %b expected 0001", if0.push); else passed++;
    total++; if (if0.data_out !== 12'h055) $display("FAIL gstall_release_data: got %h expected 055", if0.data_out); else passed++;
    @(posedge clk); #1;
    total++; if (if0.push !== 4'b0) $display("FAIL gstall_after_push: got %b expected 0000", if0.push); else passed++;
  endtask

  task automatic test_dest_stall();
    logic [11:0] din  [6];
    logic        epop [6];
    logic [3:0]  epush[6];
    logic [11:0] edata[6];
    din[0]=12'h4A1; din[1]=12'h8B2; din[2]=12'h0C3; din[3]=12'h0C3; din[4]=12'h0C3; din[5]=12'h000;
    epop[0]=1; epop[1]=1; epop[2]=0; epop[3]=0; epop[4]=1; epop[5]=0;
    epush[0]=4'b0000; epush[1]=4'b0010; epush[2]=4'b0000; epush[3]=4'b0000; epush[4]=4'b0100; epush[5]=4'b0001;
    edata[0]=12'h000; edata[1]=12'h4A1; edata[2]=12'h4A1; edata[3]=12'h4A1; edata[4]=12'h8B2; edata[5]=12'h0C3;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      almost_full = (i < 4) ? 4'b0100 : 4'b0000;
      fifo_data   = din[i];
      fifo_empty  = (i == 5);
      #1;
      total++; if (if1.pop !== epop[i]) $display("FAIL dstall_pop[%0d]: got %b expected %b", i, if1.pop, epop[i]); else passed++;
      @(posedge clk); #1;
      total++; if (if1.push !== epush[i]) $display("FAIL dstall_push[%0d]: got %b expected %b", i, if1.push, epush[i]); else passed++;
      total++; if (if1.data_out !== edata[i]) $display("FAIL dstall_data[%0d]: got %h expected %h", i, if1.data_out, edata[i]); else passed++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 11; i++) begin
      if (i < 9) begin fifo_data = 12'hC00 | 12'(i); fifo_empty = 1'b0; end
      else fifo_empty = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (push_cnt2[9 +: 3] !== 3'd7) $display("FAIL sat_cnt3: got %0d expected 7", push_cnt2[9 +: 3]); else passed++;
    total++; if (push_cnt2[8:0] !== 9'd0) $display("FAIL sat_other_cnt: got %h expected 000", push_cnt2[8:0]); else passed++;
    total++; if (push_cnt0[24 +: 8] !== 8'd9) $display("FAIL wide_cnt3: got %0d expected 9", push_cnt0[24 +: 8]); else passed++;
    fifo_data = 12'hC55; fifo_empty = 1'b0;
    @(posedge clk); #1;
    fifo_empty = 1'b1; cnt_clr = 1'b1;
    @(posedge clk); #1;
    total++; if (if2.push !== 4'b1000) $display("FAIL clr_push: got %b expected 1000", if2.push); else passed++;
    total++; if (push_cnt2 !== 12'h0) $display("FAIL clr_cnt: got %h expected 000", push_cnt2); else passed++;
    cnt_clr = 1'b0;
    @(posedge clk); #1;
    total++; if (push_cnt2 !== 12'h0) $display("FAIL clr_cnt_hold: got %h expected 000", push_cnt2); else passed++;
  endtask

  task automatic test_enable();
    logic [11:0] q   [$];
    logic [11:0] exp [$];
    logic        pop_s;
    int          got = 0;
    do_reset();
    q = '{12'h101, 12'h502, 12'h903, 12'hD04, 12'h205, 12'h606};
    exp = q;
    for (int n = 0; n < 30; n++) begin
      enable     = !(n >= 2 && n < 5);
      fifo_empty = (q.size() == 0);
      if (q.size() != 0) fifo_data = q[0];
      #1;
      pop_s = if0.pop;
      if (!enable) begin
        total++; if (pop_s !== 1'b0) $display("FAIL en_pop[%0d]: got %b expected 0", n, pop_s); else passed++;
      end
      @(posedge clk); #1;
      if (pop_s) void'(q.pop_front());
      if (!enable) begin
        total++; if (if0.push !== 4'b0) $display("FAIL en_push[%0d]: got %b expected 0000", n, if0.push); else passed++;
      end
      if (if0.push !== 4'b0) begin
        total++;
        if (got < 6 && if0.data_out === exp[got] && if0.push === 4'(1 << if0.data_out[11:10])) passed++;
        else $display("FAIL en_order[%0d]: got data %h push %b expected data %h", got, if0.data_out, if0.push, (got < 6) ? exp[got] : 12'hxxx);
        got++;
      end
    end
    enable = 1'b1;
    total++; if (got !== 6) $display("FAIL en_count: got %0d expected 6", got); else passed++;
    total++; if (q.size() !== 0) $display("FAIL en_drained: got %0d left expected 0", q.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_global_stall();
    test_dest_stall();
    test_saturation();
    test_enable();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
